// File: rtl/intt_stage_if.sv
// intt_stage_if: coefficient stream, zeta ROM and status bundle for one
// inverse-NTT stage. The master side is the environment (it sources the
// input pairs and the ROM data); the slave side is the stage itself.
interface intt_stage_if #(
    parameter int DATA_WIDTH = 12,
    parameter int LOG_N      = 8
);
    logic                  in_en;
    logic [DATA_WIDTH-1:0] in0;
    logic [DATA_WIDTH-1:0] in1;
    logic [LOG_N-2:0]      rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  out_en;
    logic [DATA_WIDTH-1:0] out0;
    logic [DATA_WIDTH-1:0] out1;
    logic                  frame_err;

    modport master (
        output in_en, in0, in1, rom_data,
        input  rom_addr, out_en, out0, out1, frame_err
    );

    modport slave (
        input  in_en, in0, in1, rom_data,
        output rom_addr, out_en, out0, out1, frame_err
    );
endinterface

// File: rtl/intt_stage.sv
// intt_stage: one pipelined inverse-NTT stage.
//   Gentleman-Sande butterfly u = a+b, v = (a-b)*zeta mod Q, followed by a
//   delay-switch-delay commutator of span D = 2^SWITCH_INDEX.
//   Latency from input pair k to output pair k is 1 + MUL_LAT + D cycles.
// Optional build macro: INTT_HALVE_EN -- when defined, u and v are halved
//   mod Q ahead of the commutator so the N^-1 scaling is spread over stages.
module intt_stage #(
    parameter int DATA_WIDTH   = 12,
    parameter int Q            = 3329,
    parameter int LOG_N        = 8,
    parameter int SWITCH_INDEX = 0,
    parameter int MUL_LAT      = 3
) (
    input  logic       clk,
    input  logic       rst,
    intt_stage_if.slave bus_io
);
    localparam int W  = DATA_WIDTH;
    localparam int KW = LOG_N - 1;
    localparam int D  = 1 << SWITCH_INDEX;

    localparam logic [W:0]    Q_X   = (W+1)'(Q);
    localparam logic [KW-1:0] K_ONE = KW'(1);

    // Exact reduction of a double-width product: restoring shift-subtract
    // over every product bit keeps the remainder below Q at each step.
    function automatic logic [W-1:0] mod_q(input logic [2*W-1:0] p);
        logic [W:0] r;
        r = '0;
        for (int i = 2*W-1; i >= 0; i--) begin
            r = {r[W-1:0], p[i]};
            if (r >= Q_X) begin
                r = r - Q_X;
            end
        end
        return r[W-1:0];
    endfunction

`ifdef INTT_HALVE_EN
    // x/2 mod Q: even values shift, odd values become even by adding Q.
    function automatic logic [W-1:0] halve_mod(input logic [W-1:0] x);
        return x[0] ? W'(({1'b0, x} + Q_X) >> 1) : (x >> 1);
    endfunction
`endif

    // ------------------------------------------------------------------
    // Pair counter and frame error detection
    // ------------------------------------------------------------------
    logic [KW-1:0] k_q, k_d;
    logic          frame_err_q, frame_err_d;

    // Next pair index; any idle cycle restarts the frame, a nonzero count
    // at that moment means the frame was cut short.
    always_comb begin
        k_d         = bus_io.in_en ? (k_q + K_ONE) : '0;
        frame_err_d = !bus_io.in_en && (k_q != '0);
    end

    // Counter and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= '0;
            frame_err_q <= 1'b0;
        end else begin
            k_q         <= k_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus_io.rom_addr  = k_q;
    assign bus_io.frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // Butterfly add/subtract (first pipeline stage)
    // ------------------------------------------------------------------
    logic [W:0]   sum_w, diff_w;
    logic [W-1:0] s1_u_d, s1_d_d;

    // Modular sum and difference of the incoming pair; inputs are < Q so a
    // single correction step suffices for each.
    always_comb begin
        sum_w = {1'b0, bus_io.in0} + {1'b0, bus_io.in1};
        if (sum_w >= Q_X) begin
            sum_w = sum_w - Q_X;
        end
        diff_w = {1'b0, bus_io.in0} - {1'b0, bus_io.in1};
        if (bus_io.in0 < bus_io.in1) begin
            diff_w = diff_w + Q_X;
        end
        s1_u_d = sum_w[W-1:0];
        s1_d_d = diff_w[W-1:0];
    end

    logic         s1_vld_q;
    logic [W-1:0] s1_u_q, s1_d_q;
    logic         s1_sw_q;

    // Stage-1 registers; zeta for this pair arrives from the ROM now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_u_q   <= '0;
            s1_d_q   <= '0;
            s1_sw_q  <= 1'b0;
        end else begin
            s1_vld_q <= bus_io.in_en;
            s1_u_q   <= s1_u_d;
            s1_d_q   <= s1_d_d;
            s1_sw_q  <= k_q[SWITCH_INDEX];
        end
    end

    // ------------------------------------------------------------------
    // Modular multiplier: exactly MUL_LAT register stages
    // ------------------------------------------------------------------
    logic [2*W-1:0] prod_w;
    logic [W-1:0]   v_mul;

    assign prod_w = {{W{1'b0}}, s1_d_q} * {{W{1'b0}}, bus_io.rom_data};

    generate
        if (MUL_LAT == 1) begin : g_mul_single
            logic [W-1:0] v_q;

            // Multiply and reduce within one stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= '0;
                end else begin
                    v_q <= mod_q(prod_w);
                end
            end

            assign v_mul = v_q;
        end else begin : g_mul_multi
            logic [2*W-1:0] prod_q;
            logic [W-1:0]   red_q [MUL_LAT-1];

            // Raw product register, then reduction, then balance delay.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod_q <= '0;
                    for (int i = 0; i < MUL_LAT-1; i++) begin
                        red_q[i] <= '0;
                    end
                end else begin
                    prod_q   <= prod_w;
                    red_q[0] <= mod_q(prod_q);
                    for (int i = 1; i < MUL_LAT-1; i++) begin
                        red_q[i] <= red_q[i-1];
                    end
                end
            end

            assign v_mul = red_q[MUL_LAT-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // u, valid and switch-bit delay matching the multiplier
    // ------------------------------------------------------------------
    logic [W-1:0] u_pipe_q   [MUL_LAT];
    logic         vld_pipe_q [MUL_LAT];
    logic         sw_pipe_q  [MUL_LAT];

    // Keep u, valid and the pair-index switch bit aligned with v.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                u_pipe_q[i]   <= '0;
                vld_pipe_q[i] <= 1'b0;
                sw_pipe_q[i]  <= 1'b0;
            end
        end else begin
            u_pipe_q[0]   <= s1_u_q;
            vld_pipe_q[0] <= s1_vld_q;
            sw_pipe_q[0]  <= s1_sw_q;
            for (int i = 1; i < MUL_LAT; i++) begin
                u_pipe_q[i]   <= u_pipe_q[i-1];
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                sw_pipe_q[i]  <= sw_pipe_q[i-1];
            end
        end
    end

    logic [W-1:0] u_h, v_h;

`ifdef INTT_HALVE_EN
    assign u_h = halve_mod(u_pipe_q[MUL_LAT-1]);
    assign v_h = halve_mod(v_mul);
`else
    assign u_h = u_pipe_q[MUL_LAT-1];
    assign v_h = v_mul;
`endif

    // ------------------------------------------------------------------
    // Delay-switch-delay commutator
    // ------------------------------------------------------------------
    logic [W-1:0] v_dly_q   [D];
    logic [W-1:0] top_dly_q [D];
    logic         vld_c_q   [D];
    logic [W-1:0] lane0_sw, lane1_sw;

    // Exchange lanes when the aligned pair index has its span bit set, so
    // each 2D group leaves as all u pairs followed by all v pairs.
    always_comb begin
        lane0_sw = u_h;
        lane1_sw = v_dly_q[D-1];
        if (sw_pipe_q[MUL_LAT-1]) begin
            lane0_sw = v_dly_q[D-1];
            lane1_sw = u_h;
        end
    end

    // Free-running D-deep delays: lane 1 before the switch, lane 0 after
    // it, plus the matching valid delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                v_dly_q[i]   <= '0;
                top_dly_q[i] <= '0;
                vld_c_q[i]   <= 1'b0;
            end
        end else begin
            v_dly_q[0]   <= v_h;
            top_dly_q[0] <= lane0_sw;
            vld_c_q[0]   <= vld_pipe_q[MUL_LAT-1];
            for (int i = 1; i < D; i++) begin
                v_dly_q[i]   <= v_dly_q[i-1];
                top_dly_q[i] <= top_dly_q[i-1];
                vld_c_q[i]   <= vld_c_q[i-1];
            end
        end
    end

    // Lane 1 leaves straight from the switch; its sources are all reset
    // registers, so it reads 0 while rst is asserted.
    assign bus_io.out_en = vld_c_q[D-1];
    assign bus_io.out0   = top_dly_q[D-1];
    assign bus_io.out1   = lane1_sw;

endmodule

// File: tb/tb_intt_stage.sv
// tb_intt_stage: random-stimulus bench for intt_stage with two instances
// (span D=1 and D=2) sharing the same input stream. A cycle-indexed history
// of the input pairs is kept; expected outputs are derived from the
// butterfly arithmetic and the documented group output order.
`timescale 1ns/1ps
module tb_intt_stage;
    localparam int W       = 12;
    localparam int Q       = 3329;
    localparam int LOG_N   = 8;
    localparam int MUL_LAT = 3;
    localparam int HALF_N  = 1 << (LOG_N - 1);
    localparam int D0      = 1;
    localparam int D1      = 2;
    localparam int LAT0    = 1 + MUL_LAT + D0;
    localparam int LAT1    = 1 + MUL_LAT + D1;
    localparam int HMAX    = 4096;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    intt_stage_if #(.DATA_WIDTH(W), .LOG_N(LOG_N)) if0 ();
    intt_stage_if #(.DATA_WIDTH(W), .LOG_N(LOG_N)) if1 ();

    intt_stage #(
        .DATA_WIDTH(W), .Q(Q), .LOG_N(LOG_N), .SWITCH_INDEX(0), .MUL_LAT(MUL_LAT)
    ) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .bus_io(if0)
    );

    intt_stage #(
        .DATA_WIDTH(W), .Q(Q), .LOG_N(LOG_N), .SWITCH_INDEX(1), .MUL_LAT(MUL_LAT)
    ) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .bus_io(if1)
    );

    // External synchronous zeta ROM, one per instance.
    int rom_tbl [HALF_N];

    always @(posedge clk) begin
        if0.rom_data <= W'(rom_tbl[if0.rom_addr]);
        if1.rom_data <= W'(rom_tbl[if1.rom_addr]);
    end

    // Reference history, indexed by input cycle.
    int  hist_a  [HMAX];
    int  hist_b  [HMAX];
    int  hist_k  [HMAX];
    bit  hist_en [HMAX];
    bit  hist_ok [HMAX];
    bit  exp_err [HMAX+1];
    int  cyc;
    int  kk;
    int  fstart;
    int  n_checks;
    int  n_pass;
    int  n_frames;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int halve(input int x);
`ifdef INTT_HALVE_EN
        return (x % 2 == 1) ? (x + Q) / 2 : x / 2;
`else
        return x;
`endif
    endfunction

    function automatic int u_of(input int n);
        return halve((hist_a[n] + hist_b[n]) % Q);
    endfunction

    function automatic int v_of(input int n);
        int d;
        d = (hist_a[n] - hist_b[n] + Q) % Q;
        return halve((d * rom_tbl[hist_k[n]]) % Q);
    endfunction

    // Expected output of one instance in the current cycle.
    task automatic check_lane(input string nm, input int d, input int lat,
                              input int en_o, input int o0, input int o1);
        int c;
        int m;
        int x0;
        int x1;
        c = cyc - lat;
        if (c < 0) begin
            check_eq({nm, ".out_en"}, en_o, 0);
        end else begin
            check_eq({nm, ".out_en"}, en_o, int'(hist_en[c]));
            if (hist_en[c] && hist_ok[c]) begin
                m = hist_k[c] % (2 * d);
                if (m < d) begin
                    x0 = u_of(c);
                    x1 = u_of(c + d);
                end else begin
                    x0 = v_of(c - d);
                    x1 = v_of(c);
                end
                check_eq({nm, ".out0"}, o0, x0);
                check_eq({nm, ".out1"}, o1, x1);
            end
        end
    endtask

    // One clock cycle: drive inputs, update the reference at the edge,
    // then compare everything on the falling edge.
    task automatic step(input bit en, input int a, input int b);
        if0.in_en = en;
        if0.in0   = W'(a);
        if0.in1   = W'(b);
        if1.in_en = en;
        if1.in0   = W'(a);
        if1.in1   = W'(b);
        @(posedge clk);
        if (rst) begin
            hist_en[cyc]     = 1'b0;
            hist_ok[cyc]     = 1'b0;
            exp_err[cyc + 1] = 1'b0;
            kk = 0;
        end else begin
            hist_en[cyc]     = en;
            hist_ok[cyc]     = en;
            hist_a[cyc]      = a;
            hist_b[cyc]      = b;
            hist_k[cyc]      = kk;
            exp_err[cyc + 1] = !en && (kk != 0);
            if (!en && kk != 0) begin
                for (int i = fstart; i < cyc; i++) begin
                    hist_ok[i] = 1'b0;
                end
            end
            if (en) begin
                if (kk == 0) begin
                    fstart = cyc;
                end
                kk = (kk + 1) % HALF_N;
            end else begin
                kk = 0;
            end
        end
        cyc++;
        @(negedge clk);
        check_eq("dut0.rom_addr", int'(if0.rom_addr), kk);
        check_eq("dut1.rom_addr", int'(if1.rom_addr), kk);
        check_eq("dut0.frame_err", int'(if0.frame_err), int'(exp_err[cyc]));
        check_eq("dut1.frame_err", int'(if1.frame_err), int'(exp_err[cyc]));
        check_lane("dut0", D0, LAT0, int'(if0.out_en), int'(if0.out0), int'(if0.out1));
        check_lane("dut1", D1, LAT1, int'(if1.out_en), int'(if1.out0), int'(if1.out1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 0, 0);
        end
    endtask

    task automatic zero_checks(input string nm);
        check_eq({nm, ".dut0.out_en"}, int'(if0.out_en), 0);
        check_eq({nm, ".dut0.out0"}, int'(if0.out0), 0);
        check_eq({nm, ".dut0.out1"}, int'(if0.out1), 0);
        check_eq({nm, ".dut0.frame_err"}, int'(if0.frame_err), 0);
        check_eq({nm, ".dut1.out_en"}, int'(if1.out_en), 0);
        check_eq({nm, ".dut1.out0"}, int'(if1.out0), 0);
        check_eq({nm, ".dut1.out1"}, int'(if1.out1), 0);
        check_eq({nm, ".dut1.frame_err"}, int'(if1.frame_err), 0);
    endtask

    // Frame of npairs pairs; the directed frame opens with known cases.
    task automatic frame(input int npairs, input bit directed);
        int dir_a [9];
        int dir_b [9];
        int a;
        int b;
        dir_a = '{10, 11, 12, 13, 5, 3, 3000, Q-1, 0};
        dir_b = '{1, 1, 1, 1, 3, 5, 1000, Q-1, Q-1};
        n_frames++;
        $display("frame %0d: %0d pairs starting at cycle %0d", n_frames, npairs, cyc);
        for (int i = 0; i < npairs; i++) begin
            if (directed && i < 9) begin
                a = dir_a[i];
                b = dir_b[i];
            end else begin
                a = int'($urandom_range(0, Q-1));
                b = int'($urandom_range(0, Q-1));
            end
            step(1'b1, a, b);
        end
    endtask

    // Asynchronous reset in the middle of a frame.
    task automatic reset_mid();
        rst = 1'b1;
        #1;
        zero_checks("async_rst");
        for (int i = 0; i < HMAX; i++) begin
            hist_en[i] = 1'b0;
            hist_ok[i] = 1'b0;
            exp_err[i] = 1'b0;
        end
        kk = 0;
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_frames = 0;
        cyc      = 0;
        kk       = 0;
        fstart   = 0;
        for (int i = 0; i < HMAX; i++) begin
            hist_en[i] = 1'b0;
            hist_ok[i] = 1'b0;
            exp_err[i] = 1'b0;
        end
        exp_err[HMAX] = 1'b0;
        for (int i = 0; i < HALF_N; i++) begin
            rom_tbl[i] = int'($urandom_range(0, Q-1));
        end
        rom_tbl[0] = 1; rom_tbl[1] = 1; rom_tbl[2] = 1; rom_tbl[3] = 1;
        rom_tbl[4] = 1; rom_tbl[5] = 17; rom_tbl[6] = 1;
        rom_tbl[7] = Q-1; rom_tbl[8] = 0;

        rst = 1'b1;
        if0.in_en = 1'b0; if0.in0 = '0; if0.in1 = '0;
        if1.in_en = 1'b0; if1.in0 = '0; if1.in1 = '0;
        idle(3);
        zero_checks("init_rst");
        rst = 1'b0;
        idle(2);

        // Directed opening frame, then a back-to-back frame with no gap.
        frame(HALF_N, 1'b1);
        frame(HALF_N, 1'b0);
        idle(3);
        frame(HALF_N, 1'b0);
        idle(1);

        // Mid-frame drop after 5 pairs, then a clean frame.
        frame(5, 1'b0);
        idle(4);
        frame(HALF_N, 1'b0);
        idle(int'($urandom_range(0, 3)));

        // Reset during a frame while outputs are active.
        frame(60, 1'b0);
        reset_mid();
        frame(HALF_N, 1'b1);

        // Frames with small random gaps.
        for (int f = 0; f < 2; f++) begin
            idle(int'($urandom_range(0, 2)));
            frame(HALF_N, 1'b0);
        end

        idle(LAT1 + 4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/intt_stage.md
Name: intt_stage

Overview:
- One pipelined inverse-NTT stage using a Gentleman-Sande (GS) butterfly.
- It takes a dual-lane coefficient stream, one pair per cycle. It computes u=a+b and v=(a-b)*zeta mod Q, then reorders pairs through a delay-switch-delay commutator with span D=2^SWITCH_INDEX.
- LOG_N-1 instances are chained, with SWITCH_INDEX ascending, to form the inverse transform that mirrors the forward NTT pipeline.
- Zeta comes from an external per-stage synchronous ROM.

Parameters:
- DATA_WIDTH, 12, coefficient width.
- Q, 3329, modulus; Q < 2^DATA_WIDTH.
- LOG_N, 8, log2 of polynomial length N.
- SWITCH_INDEX, 0, commutator span exponent; legal range 0..LOG_N-2; D=2^SWITCH_INDEX.
- MUL_LAT, 3, modular multiplier pipeline depth in cycles; must be >=1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-high.
- in_en, input, 1, input pair valid; held high for N/2 consecutive cycles per polynomial.
- in0, input, DATA_WIDTH, coefficient a, value < Q.
- in1, input, DATA_WIDTH, coefficient b, value < Q.
- rom_addr, output, LOG_N-1, zeta address = pair index k of the current input cycle.
- rom_data, input, DATA_WIDTH, zeta; valid one cycle after rom_addr.
- out_en, output, 1, output pair valid.
- out0, output, DATA_WIDTH, output lane 0.
- out1, output, DATA_WIDTH, output lane 1.
- frame_err, output, 1, one-cycle pulse on an illegal mid-frame in_en drop.

Behaviour:
- Reset: pair counter k=0. All valid pipeline bits, commutator registers, out_en, out0, out1 and frame_err are cleared to 0. An in-flight frame is discarded; no partial output is emitted after reset deasserts.
- Pair counter k:
  - Increments on each cycle with in_en=1 and wraps N/2-1 -> 0.
  - Forced to 0 in any cycle with in_en=0.
  - rom_addr = k, combinational from the counter register.
- Butterfly, cycle 1 (registered):
  - s = a+b; if s >= Q then s -= Q.
  - d = a-b; if negative then d += Q.
  - zeta from rom_data aligns with d in this cycle.
- Multiply: v = (d*zeta) mod Q. Exact reduction, exactly MUL_LAT register stages. u is delayed MUL_LAT to stay aligned with v.
- Commutator:
  - Lane 1 (v) is delayed D.
  - A switch controlled by bit SWITCH_INDEX of the aligned pair index exchanges lanes.
  - Lane 0 is then delayed D.
  - Within each group of 2D input pairs (base g), the output order is:
    - First (u[g+m], u[g+m+D]) for m = 0..D-1.
    - Then (v[g+m], v[g+m+D]) for m = 0..D-1.
- Latency: LAT = 1+MUL_LAT+D cycles from the input cycle of pair k to the output cycle of output pair k. out_en is in_en delayed by exactly LAT.
- Throughput: one pair per cycle. Back-to-back frames with zero gap are legal; frames with arbitrary gaps are legal.
- Drain: all pipeline registers are free-running, so data drains correctly after in_en falls at a frame boundary.
- frame_err: registered. Pulses 1 for one cycle when in_en=0 while the counter is nonzero (mid-frame drop). The counter then resets to 0.
  - out_en still mirrors the delayed in_en; output contents for that frame are undefined.
- Simultaneous end of one frame and start of the next: the counter wraps to 0 with no bubble, and frame_err stays 0.
- Outputs never exceed Q-1.

Optional Feature:
- INTT_HALVE_EN defined:
  - Both butterfly results are halved mod Q before the commutator: x even -> x>>1; x odd -> (x+Q)>>1.
  - This folds the N^-1 scaling across stages.
  - Latency is unchanged; the halving is combinational on the last multiply stage and on the matching u delay tap.
- INTT_HALVE_EN undefined: u and v pass unscaled.

Test Plan:
- Basic butterfly, D=1, MUL_LAT=3, Q=3329: a=5, b=3, zeta=1, single frame -> u=8, v=2. Output appears 5 cycles after the input cycle.
- Subtract wrap: a=3, b=5, zeta=17 -> v=3295. Add wrap: a=3000, b=1000 -> u=671.
- Commutator, SWITCH_INDEX=1 (D=2): pairs a=10,11,12,13, b=1, zeta=1 -> outputs (11,13), (12,14), (9,11), (10,12) on 4 consecutive out_en cycles, starting LAT=6 after the first input.
- Protocol error: in_en drops after 5 of 128 pairs -> frame_err=1 for exactly one cycle. The next frame restarts with rom_addr=0 and produces correct output.
- Async reset asserted mid-frame -> out_en=0, out0=out1=0, frame_err=0 immediately. Next full frame output is correct; rom_addr sequence is 0..127; there are no stray out_en cycles.
- With INTT_HALVE_EN: a=3000, b=1000, zeta=1 -> u=2000. a=3, b=5, zeta=17 -> v=3312.
